// File: rtl/relay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : relay_pkg
// Description : Shared mode codes, sequencer state encoding and detector
//               constants for the relay timing datapath and its sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package relay_pkg;

  // Width of the sequencer cycle counter (parameters must be <= 2^21)
  localparam int c_cnt_w = 21;

  // Datapath mode select codes; the datapath ignores IDLE_MODE
  localparam logic [2:0] MASTER    = 3'b000;
  localparam logic [2:0] SLAVE     = 3'b001;
  localparam logic [2:0] DELAY     = 3'b010;
  localparam logic [2:0] IDLE_MODE = 3'b111;

  // Reply preamble pattern, newest sample in the LSB
  localparam logic [3:0] c_preamble   = 4'ha;
  // Divider value on which a sample tick fires
  localparam logic [3:0] c_tick_phase = 4'hc;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MASTER = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DELAY  = 3'd3,
    ST_SLAVE  = 3'd4
  } state_t;

  // Mode presented to the datapath while in a given state
  function automatic logic [2:0] mode_of(input state_t s);
    logic [2:0] m;
    case (s)
      ST_MASTER: m = MASTER;
      ST_DRAIN:  m = MASTER;
      ST_DELAY:  m = DELAY;
      ST_SLAVE:  m = SLAVE;
      default:   m = IDLE_MODE;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/relay_preamble_det.sv
`default_nettype none
// ============================================================================
// Module      : relay_preamble_det
// Description : Free-running 1-in-16 sample tick generator and 4-bit reply
//               preamble detector on the relay line.
// Revision    : 1.0 - initial release
// ============================================================================
module relay_preamble_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_data,
  output logic o_tick,
  output logic o_match
);
  import relay_pkg::*;

  logic [3:0] r_div;
  logic [3:0] r_sr;
  logic [3:0] w_sr_shift;

  // Free-running sample divider, never cleared except by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 4'd0;
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  assign o_tick     = (r_div == c_tick_phase);
  assign w_sr_shift = {r_sr[2:0], i_data};
  // Match looks at the register including the bit arriving on this tick
  assign o_match    = o_tick && (w_sr_shift == c_preamble);

  // Sample shift register; clear wins over a coincident tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr <= 4'd0;
    end else if (i_clr) begin
      r_sr <= 4'd0;
    end else if (o_tick) begin
      r_sr <= w_sr_shift;
    end
  end

endmodule
`default_nettype wire

// File: rtl/relay_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : relay_sequencer
// Description : Owns the datapath mode select and sequences a relay timing
//               measurement (MASTER -> DRAIN -> DELAY) or a SLAVE session.
// Revision    : 1.0 - initial release
// ============================================================================
module relay_sequencer #(
  parameter int unsigned TIMEOUT_CYC    = 1048576,
  parameter int unsigned DRAIN_TICKS    = 2,
  parameter int unsigned DELAY_HOLD_CYC = 524416
) (
  input  logic       ck_1356meg,
  input  logic       reset_n,
  input  logic       start,
  input  logic       slave_en,
  input  logic       abort,
  input  logic       data_in,
  output logic [2:0] mod_type,
  output logic       busy,
  output logic       done,
  output logic       timeout
);
  import relay_pkg::*;

  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_drain_last   = c_cnt_w'(DRAIN_TICKS - 1);
  localparam logic [c_cnt_w-1:0] c_delay_last   = c_cnt_w'(DELAY_HOLD_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max      = '1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic [c_cnt_w-1:0] r_tcnt;
  logic [c_cnt_w-1:0] w_tcnt_nxt;
  logic               w_done_nxt;
  logic               w_timeout_nxt;
  logic               w_det_clr;
  logic               w_tick;
  logic               w_match;
  logic [2:0]         r_mod;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout;

  relay_preamble_det u_det (
    .clk     (ck_1356meg),
    .rst_n   (reset_n),
    .i_clr   (w_det_clr),
    .i_data  (data_in),
    .o_tick  (w_tick),
    .o_match (w_match)
  );

  // Cycle counter saturates instead of wrapping
  assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_w'(1);

  // Next-state, counter and output decode; abort overrides everything
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_tcnt_nxt    = r_tcnt;
    w_done_nxt    = 1'b0;
    w_timeout_nxt = r_timeout;
    w_det_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt   = ST_MASTER;
          w_timeout_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_det_clr     = 1'b1;
        end else if (slave_en) begin
          w_state_nxt = ST_SLAVE;
        end
      end
      ST_MASTER: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_match) begin
          w_state_nxt = ST_DRAIN;
          w_tcnt_nxt  = '0;
        end else if (r_cnt == c_timeout_last) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_tick) begin
          if (r_tcnt == c_drain_last) begin
            w_state_nxt = ST_DELAY;
            w_cnt_nxt   = '0;
          end else begin
            w_tcnt_nxt = r_tcnt + c_cnt_w'(1);
          end
        end
      end
      ST_DELAY: begin
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == c_delay_last) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      ST_SLAVE: begin
        if (!slave_en) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      w_done_nxt    = 1'b0;
      w_timeout_nxt = r_timeout;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge ck_1356meg or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_mod     <= IDLE_MODE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_mod     <= mode_of(w_state_nxt);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign mod_type = r_mod;
  assign busy     = r_busy;
  assign done     = r_done;
  assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_relay_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_relay_sequencer
// Description : Self-checking bench for relay_sequencer with an event-level
//               reference model (absolute edge times, sample history queue).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relay_sequencer;

  localparam int unsigned TIMEOUT_CYC    = 1000;
  localparam int unsigned DRAIN_TICKS    = 2;
  localparam int unsigned DELAY_HOLD_CYC = 200;

  localparam int P_IDLE   = 0;
  localparam int P_MASTER = 1;
  localparam int P_DRAIN  = 2;
  localparam int P_DELAY  = 3;
  localparam int P_SLAVE  = 4;

  logic       ck_1356meg = 1'b0;
  logic       reset_n    = 1'b0;
  logic       start      = 1'b0;
  logic       slave_en   = 1'b0;
  logic       abort      = 1'b0;
  logic       data_in    = 1'b0;
  logic [2:0] mod_type;
  logic       busy;
  logic       done;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase, edge index since reset release, phase start time
  int m_n;
  int m_phase;
  int m_mark;
  int m_left;
  bit m_to;
  bit m_done;
  bit m_smp[$];

  relay_sequencer #(
    .TIMEOUT_CYC    (TIMEOUT_CYC),
    .DRAIN_TICKS    (DRAIN_TICKS),
    .DELAY_HOLD_CYC (DELAY_HOLD_CYC)
  ) dut (
    .ck_1356meg (ck_1356meg),
    .reset_n    (reset_n),
    .start      (start),
    .slave_en   (slave_en),
    .abort      (abort),
    .data_in    (data_in),
    .mod_type   (mod_type),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_mod(input int ph);
    case (ph)
      P_MASTER, P_DRAIN: return 3'b000;
      P_DELAY:           return 3'b010;
      P_SLAVE:           return 3'b001;
      default:           return 3'b111;
    endcase
  endfunction

  // True when the last four samples taken since MASTER entry read 1,0,1,0
  function automatic bit saw_preamble();
    int s;
    s = m_smp.size();
    if (s < 4) return 1'b0;
    return (m_smp[s-4] == 1'b1) && (m_smp[s-3] == 1'b0) &&
           (m_smp[s-2] == 1'b1) && (m_smp[s-1] == 1'b0);
  endfunction

  task automatic model_edge();
    bit tick;
    bit hit;
    tick   = ((m_n % 16) == 12);
    hit    = 1'b0;
    m_done = 1'b0;
    if (m_phase != P_IDLE && abort) begin
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (start) begin
            m_phase = P_MASTER;
            m_mark  = m_n;
            m_to    = 1'b0;
            m_smp.delete();
          end else if (slave_en) begin
            m_phase = P_SLAVE;
          end
        end
        P_MASTER: begin
          if (tick) begin
            m_smp.push_back(data_in);
            hit = saw_preamble();
          end
          if (hit) begin
            m_phase = P_DRAIN;
            m_left  = DRAIN_TICKS;
          end else if (m_n - m_mark == TIMEOUT_CYC) begin
            m_phase = P_IDLE;
            m_to    = 1'b1;
          end
        end
        P_DRAIN: begin
          if (tick) begin
            m_left--;
            if (m_left == 0) begin
              m_phase = P_DELAY;
              m_mark  = m_n;
            end
          end
        end
        P_DELAY: begin
          if (m_n - m_mark == DELAY_HOLD_CYC) begin
            m_phase = P_IDLE;
            m_done  = 1'b1;
          end
        end
        default: begin
          if (!slave_en) m_phase = P_IDLE;
        end
      endcase
    end
    m_n++;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge ck_1356meg);
    model_edge();
    @(negedge ck_1356meg);
    check("outs", {26'd0, mod_type, busy, done, timeout},
          {26'd0, exp_mod(m_phase), (m_phase != P_IDLE), m_done, m_to});
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    slave_en = 1'b0;
    data_in  = 1'b0;
    repeat (2) @(posedge ck_1356meg);
    @(negedge ck_1356meg);
    check("rst_outs", {26'd0, mod_type, busy, done, timeout}, {26'd0, 3'b111, 3'b000});
    reset_n = 1'b1;
    m_n     = 0;
    m_phase = P_IDLE;
    m_to    = 1'b0;
    m_done  = 1'b0;
    m_smp.delete();
  endtask

  // Present `quiet` zero samples then 1,0,1,0 on successive ticks
  task automatic feed_preamble(input int quiet);
    for (int i = 0; i < quiet + 4; i++) begin
      data_in = (i >= quiet) && (((i - quiet) % 2) == 0);
      while ((m_n % 16) != 12) cycle();
      cycle();
    end
    data_in = 1'b0;
  endtask

  task automatic run_until(input string tag, input int ph, input int max_cyc);
    int k;
    k = 0;
    while (m_phase != ph && k < max_cyc) begin
      cycle();
      k++;
    end
    if (k >= max_cyc) check({tag, "_budget"}, k, max_cyc - 1);
    check(tag, 32'(mod_type), 32'(exp_mod(ph)));
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int dn;
    int tgt;
    int e;

    do_reset();

    // Full measurement with preamble on ticks 3..6
    start = 1'b1;
    cycle();
    check("start_mode", 32'(mod_type), 32'h0);
    check("start_busy", 32'(busy), 32'h1);
    feed_preamble(2);
    check("drain_mode", 32'(mod_type), 32'h0);
    k = 0;
    while (mod_type == 3'b000 && k < 100) begin cycle(); k++; end
    check("drain_len", k, DRAIN_TICKS * 16);
    check("delay_mode", 32'(mod_type), 32'h2);
    k = 0;
    while (mod_type == 3'b010 && k < DELAY_HOLD_CYC + 10) begin cycle(); k++; end
    check("delay_len", k, DELAY_HOLD_CYC);
    check("done_pulse", 32'(done), 32'h1);
    check("done_busy", 32'(busy), 32'h0);
    check("done_no_to", 32'(timeout), 32'h0);
    cycle();
    check("done_clear", 32'(done), 32'h0);

    // Timeout with data_in held low
    data_in = 1'b0;
    start = 1'b1;
    cycle();
    k = 0;
    while (busy && k < TIMEOUT_CYC + 10) begin cycle(); k++; end
    check("timeout_len", k, TIMEOUT_CYC);
    check("timeout_set", 32'(timeout), 32'h1);
    check("timeout_mode", 32'(mod_type), 32'h7);
    check("timeout_nodone", 32'(done), 32'h0);
    repeat (3) cycle();
    start = 1'b1;
    cycle();
    check("timeout_clr", 32'(timeout), 32'h0);
    abort = 1'b1;
    cycle();
    check("abort_master", 32'(mod_type), 32'h7);

    // Slave session, start ignored inside it
    slave_en = 1'b1;
    cycle();
    check("slave_mode", 32'(mod_type), 32'h1);
    check("slave_busy", 32'(busy), 32'h1);
    repeat (20) begin
      start = $urandom_range(0, 1);
      cycle();
    end
    check("slave_hold", 32'(mod_type), 32'h1);
    slave_en = 1'b0;
    cycle();
    check("slave_exit", 32'(mod_type), 32'h7);

    // Abort in DELAY
    start = 1'b1;
    cycle();
    feed_preamble(0);
    run_until("to_delay", P_DELAY, 200);
    repeat ($urandom_range(1, DELAY_HOLD_CYC - 5)) cycle();
    abort = 1'b1;
    cycle();
    check("abort_delay", 32'(mod_type), 32'h7);
    dn = 0;
    repeat (DELAY_HOLD_CYC + 20) begin
      cycle();
      if (done) dn++;
    end
    check("abort_nodone", dn, 0);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    cycle();
    check("start_abort", 32'(mod_type), 32'h0);
    check("start_abort_busy", 32'(busy), 32'h1);
    abort = 1'b1;
    cycle();

    // Preamble completes on the timeout edge
    tgt = (12 - int'(TIMEOUT_CYC % 16) + 16) % 16;
    k = 0;
    while ((m_n % 16) != tgt && k < 20) begin cycle(); k++; end
    start = 1'b1;
    e = m_n + TIMEOUT_CYC;
    cycle();
    k = 0;
    while (m_n <= e && k < TIMEOUT_CYC + 10) begin
      data_in = (m_n == e - 48) || (m_n == e - 16);
      cycle();
      k++;
    end
    data_in = 1'b0;
    check("coinc_mode", 32'(mod_type), 32'h0);
    check("coinc_busy", 32'(busy), 32'h1);
    check("coinc_no_to", 32'(timeout), 32'h0);
    run_until("coinc_end", P_IDLE, 400);

    // Asynchronous reset in DRAIN
    start = 1'b1;
    cycle();
    feed_preamble(1);
    repeat (5) cycle();
    #2 reset_n = 1'b0;
    #1;
    check("async_mode", 32'(mod_type), 32'h7);
    check("async_busy", 32'(busy), 32'h0);
    do_reset();
    start = 1'b1;
    cycle();
    feed_preamble(0);
    run_until("fresh_end", P_IDLE, 400);
    check("fresh_done", 32'(done), 32'h1);

    // Randomized traffic against the model
    repeat (12) begin
      repeat (500) begin
        start   = ($urandom_range(0, 39) == 0);
        abort   = ($urandom_range(0, 199) == 0);
        data_in = $urandom_range(0, 1);
        if ($urandom_range(0, 59) == 0) slave_en = ~slave_en;
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relay_sequencer.md
# relay_sequencer

Controller that owns the `mod_type` select of the relay datapath and sequences a complete relay-timing measurement. It runs three phases: MASTER while the relayed frame is sent and the peer's reply preamble is awaited, a short drain, then DELAY for the readout window. It also supports a free-running SLAVE session. The block sits between the ARM-side command register bits and the relay datapath; it watches the same `data_in` relay line as the datapath.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 1048576: clocks allowed in MASTER before the reply preamble must be seen.
- `DRAIN_TICKS`, default 2: sample ticks MASTER is held after preamble match.
- `DELAY_HOLD_CYC`, default 524416: clocks DELAY is held. The default is 65536 × 8 + 128, which covers the arm-delay wait plus the 32-bit readout.

Ports:
- `ck_1356meg`  in  1  13.56 MHz clock, the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a master measurement.
- `slave_en`  in  1  level; high in IDLE enters a SLAVE session, low ends it.
- `abort`  in  1  one-cycle request to return to IDLE from any state.
- `data_in`  in  1  relay line from the peer Proxmark.
- `mod_type`  out  3  mode select to the datapath.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a measurement completes.
- `timeout`  out  1  sticky; set on MASTER timeout, cleared on next accepted `start`.

## Operation
- Mode codes: MASTER=3'b000, SLAVE=3'b001, DELAY=3'b010, IDLE_MODE=3'b111. The datapath ignores 3'b111.
- Sample tick: a free-running 4-bit divider, reset to 0. A tick occurs when divider==4'b1100, i.e. one tick per 16 clocks.
- Preamble detector: a 4-bit shift register loads `data_in` on each tick. It is cleared to 0 on entry to MASTER. A match occurs when the register, including the bit shifted in on this tick, equals 4'ha.
- States and transitions:
  - IDLE, `mod_type`=IDLE_MODE:
    - `start` → MASTER; clear `timeout`, clear the cycle counter.
    - else `slave_en` → SLAVE.
    - `start` has priority over `slave_en`.
  - MASTER, `mod_type`=MASTER:
    - The cycle counter increments each clock.
    - Match → DRAIN with the tick counter cleared.
    - Counter reaching TIMEOUT_CYC−1 with no match → IDLE, set `timeout`.
    - If match and timeout fall on the same cycle, the match wins.
  - DRAIN, `mod_type`=MASTER: after DRAIN_TICKS ticks → DELAY with the cycle counter cleared.
  - DELAY, `mod_type`=DELAY: when the counter reaches DELAY_HOLD_CYC−1 → IDLE and pulse `done`.
  - SLAVE, `mod_type`=SLAVE: `slave_en` low → IDLE. No `done` pulse.
- `abort` in any non-IDLE state → IDLE next clock, no `done`; `timeout` is unchanged. `abort` has priority over every other transition.
- `start` is ignored when not in IDLE.
- Arithmetic: the cycle counter is 21 bits, unsigned, and never wraps; it is compared against the parameters. Parameter values must be at most 2^21.

## Timing
- Reset (async assert, sync release):
  - state IDLE, `mod_type`=3'b111.
  - `busy`=0, `done`=0, `timeout`=0.
  - divider, shift register and counters all 0.
- All outputs are registered.
- `start` sampled high at edge t → `mod_type`=MASTER and `busy`=1 after edge t.
- Match at tick edge s → DRAIN state after edge s. DRAIN ends at the DRAIN_TICKS-th tick edge after s, at which `mod_type` becomes DELAY.
- DELAY lasts exactly DELAY_HOLD_CYC clocks. On the final edge, `mod_type` returns to IDLE_MODE, `done`=1 for one clock, and `busy`=0 on that same edge.
- Timeout: `timeout`=1 and `busy`=0 exactly TIMEOUT_CYC clocks after MASTER entry.
- `reset_n` low mid-operation: all outputs return to reset values immediately (asynchronous).

## Structure
- Shared package `relay_pkg`: mode constants (MASTER, SLAVE, DELAY, IDLE_MODE) and the state encoding. The datapath uses the same mode constants.
- One sub-module, `relay_preamble_det`, containing:
  - the divider;
  - the shift register;
  - a synchronous clear input;
  - outputs `tick` and `match`.
- The FSM and counters live in the top module.

## Test plan
- Start, then drive 1010 on `data_in` at ticks 3–6 → `mod_type` goes 000 → 000 (2 ticks) → 010 for 524416 clocks → 111 with a `done` pulse; `timeout`=0.
- Start with `data_in` held 0 and TIMEOUT_CYC=1000 → after exactly 1000 clocks `mod_type`=111, `timeout`=1, no `done`. A new `start` clears `timeout`.
- `slave_en`=1 in IDLE → `mod_type`=001 and `busy`=1. A `start` pulse while in SLAVE is ignored. `slave_en`=0 → 111 next clock.
- `abort` during DELAY → `mod_type`=111 next clock, `done` never pulses. `start` and `abort` in the same IDLE cycle → MASTER, since `abort` has no effect in IDLE.
- `reset_n` asserted mid-DRAIN → `mod_type`=111 and `busy`=0 immediately, without a clock edge. After release, a fresh `start` runs normally.
- Preamble completing on the same cycle the MASTER counter reaches TIMEOUT_CYC−1 → DRAIN is entered and `timeout` stays 0.
